// File: rtl/rv_decode_pkg.sv
// Shared opcodes, ALU control codes and the delay-line entry format for the
// RV32I/RV64I decode pipe.
package rv_decode_pkg;

   localparam logic [6:0] OpcOp     = 7'h33;
   localparam logic [6:0] OpcOpImm  = 7'h13;
   localparam logic [6:0] OpcLoad   = 7'h03;
   localparam logic [6:0] OpcStore  = 7'h23;
   localparam logic [6:0] OpcBranch = 7'h63;
   localparam logic [6:0] OpcJal    = 7'h6F;
   localparam logic [6:0] OpcJalr   = 7'h67;
   localparam logic [6:0] OpcLui    = 7'h37;
   localparam logic [6:0] OpcAuipc  = 7'h17;

   typedef enum logic [3:0] {
      AluAnd   = 4'b0000,
      AluSll   = 4'b0001,
      AluAdd   = 4'b0010,
      AluOr    = 4'b0011,
      AluSub   = 4'b0100,
      AluSlt   = 4'b0101,
      AluXor   = 4'b0110,
      AluSltu  = 4'b0111,
      AluSrl   = 4'b1000,
      AluSra   = 4'b1001,
      AluJalr  = 4'b1010,
      AluJal   = 4'b1011,
      AluStore = 4'b1100,
      AluLoad  = 4'b1101,
      AluAuipc = 4'b1110,
      AluNop   = 4'b1111
   } alu_op_t;

   localparam int unsigned RegAw = 5;

   typedef struct packed {
      logic             valid;
      logic [RegAw-1:0] rs1;
      logic [RegAw-1:0] rs2;
      logic [RegAw-1:0] rd;
      logic             we;
   } regnum_t;

endpackage

// File: rtl/rv_decode_pipe_if.sv
// Fetch-side handshake plus decode and writeback outputs of rv_decode_pipe.
interface rv_decode_pipe_if #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned REG_AW = 5
);
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       inst;
   logic              stall;
   logic              flush;
   logic              dec_valid;
   logic [REG_AW-1:0] dec_rs1;
   logic [REG_AW-1:0] dec_rs2;
   logic [REG_AW-1:0] dec_rd;
   logic [XLEN-1:0]   dec_imm;
   logic [3:0]        dec_alu;
   logic              dec_we;
   logic              dec_illegal;
   logic              wb_valid;
   logic [REG_AW-1:0] wb_rs1;
   logic [REG_AW-1:0] wb_rs2;
   logic [REG_AW-1:0] wb_rd;
   logic              wb_we;

   modport master (
      output in_valid, inst, stall, flush,
      input  in_ready, dec_valid, dec_rs1, dec_rs2, dec_rd, dec_imm, dec_alu, dec_we,
      input  dec_illegal, wb_valid, wb_rs1, wb_rs2, wb_rd, wb_we
   );

   modport slave (
      input  in_valid, inst, stall, flush,
      output in_ready, dec_valid, dec_rs1, dec_rs2, dec_rd, dec_imm, dec_alu, dec_we,
      output dec_illegal, wb_valid, wb_rs1, wb_rs2, wb_rd, wb_we
   );
endinterface

// File: rtl/regnum_delay_line.sv
// Fixed-depth shift register with enable and synchronous clear.
module regnum_delay_line #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 17
) (
   input  logic         clk_i,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] stage_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else if (en_i) begin
         stage_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/rv_decode_pipe.sv
// Registered RV32I/RV64I decode stage feeding a register-number delay line
// that presents rs1/rs2/rd/we to writeback DELAY_STAGES cycles later.
module rv_decode_pipe
   import rv_decode_pkg::*;
#(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned DELAY_STAGES = 4,
   parameter int unsigned REG_AW       = 5
) (
   input logic             clk,
   input logic             rst_b,
   rv_decode_pipe_if.slave bus
);

   localparam bit          Is64 = (XLEN == 64);
   localparam int unsigned ShW  = Is64 ? 6 : 5;

   logic [6:0]        opc;
   logic [2:0]        f3;
   logic [6:0]        f7;
   logic [REG_AW-1:0] rs1_f, rs2_f, rd_f;
   logic [XLEN-1:0]   imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
   logic              sh_hi_zero, load_f3_ok, store_f3_ok;

   assign opc   = bus.inst[6:0];
   assign f3    = bus.inst[14:12];
   assign f7    = bus.inst[31:25];
   assign rs1_f = REG_AW'(bus.inst[19:15]);
   assign rs2_f = REG_AW'(bus.inst[24:20]);
   assign rd_f  = REG_AW'(bus.inst[11:7]);

   assign imm_i  = XLEN'($signed(bus.inst[31:20]));
   assign imm_s  = XLEN'($signed({bus.inst[31:25], bus.inst[11:7]}));
   assign imm_b  = XLEN'($signed({bus.inst[31], bus.inst[7], bus.inst[30:25],
                                  bus.inst[11:8], 1'b0}));
   assign imm_u  = XLEN'($signed({bus.inst[31:12], 12'b0}));
   assign imm_j  = XLEN'($signed({bus.inst[31], bus.inst[19:12], bus.inst[20],
                                  bus.inst[30:21], 1'b0}));
   assign imm_sh = XLEN'(bus.inst[20 +: ShW]);

   // Shift-immediate funct bits above the shamt, excluding inst[30] (SRA select).
   assign sh_hi_zero  = !bus.inst[31] && (bus.inst[29:20+ShW] == '0);
   assign load_f3_ok  = (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) ||
                        (Is64 && (f3 inside {3'b011, 3'b110}));
   assign store_f3_ok = (f3 < 3'd3) || (Is64 && (f3 == 3'd3));

   alu_op_t           alu_d, alu_q;
   logic [REG_AW-1:0] rs1_d, rs2_d, rd_d, rs1_q, rs2_q, rd_q;
   logic [XLEN-1:0]   imm_d, imm_q;
   logic              wr, we_d, we_q, ill_d, ill_q, valid_q;

   always_comb begin
      alu_d = AluNop;
      rs1_d = '0;
      rs2_d = '0;
      rd_d  = '0;
      imm_d = '0;
      wr    = 1'b0;
      ill_d = 1'b0;
      case (opc)
         OpcOp: begin
            rs1_d = rs1_f;
            rs2_d = rs2_f;
            rd_d  = rd_f;
            wr    = 1'b1;
            case ({f7, f3})
               {7'h00, 3'b000}: alu_d = AluAdd;
               {7'h20, 3'b000}: alu_d = AluSub;
               {7'h00, 3'b001}: alu_d = AluSll;
               {7'h00, 3'b010}: alu_d = AluSlt;
               {7'h00, 3'b011}: alu_d = AluSltu;
               {7'h00, 3'b100}: alu_d = AluXor;
               {7'h00, 3'b101}: alu_d = AluSrl;
               {7'h20, 3'b101}: alu_d = AluSra;
               {7'h00, 3'b110}: alu_d = AluOr;
               {7'h00, 3'b111}: alu_d = AluAnd;
               default:         ill_d = 1'b1;
            endcase
         end
         OpcOpImm: begin
            rs1_d = rs1_f;
            rd_d  = rd_f;
            wr    = 1'b1;
            imm_d = imm_i;
            case (f3)
               3'b000: alu_d = AluAdd;
               3'b010: alu_d = AluSlt;
               3'b011: alu_d = AluSltu;
               3'b100: alu_d = AluXor;
               3'b110: alu_d = AluOr;
               3'b111: alu_d = AluAnd;
               3'b001: begin
                  alu_d = AluSll;
                  imm_d = imm_sh;
                  ill_d = !sh_hi_zero || bus.inst[30];
               end
               default: begin
                  alu_d = bus.inst[30] ? AluSra : AluSrl;
                  imm_d = imm_sh;
                  ill_d = !sh_hi_zero;
               end
            endcase
         end
         OpcLoad: begin
            rs1_d = rs1_f;
            rd_d  = rd_f;
            wr    = 1'b1;
            imm_d = imm_i;
            alu_d = AluLoad;
            ill_d = !load_f3_ok;
         end
         OpcStore: begin
            rs1_d = rs1_f;
            rs2_d = rs2_f;
            imm_d = imm_s;
            alu_d = AluStore;
            ill_d = !store_f3_ok;
         end
         OpcBranch: begin
            rs1_d = rs1_f;
            rs2_d = rs2_f;
            imm_d = imm_b;
            ill_d = (f3[2:1] == 2'b01);
         end
         OpcJal: begin
            rd_d  = rd_f;
            wr    = 1'b1;
            imm_d = imm_j;
            alu_d = AluJal;
         end
         OpcJalr: begin
            rs1_d = rs1_f;
            rd_d  = rd_f;
            wr    = 1'b1;
            imm_d = imm_i;
            alu_d = AluJalr;
            ill_d = (f3 != 3'b000);
         end
         OpcLui: begin
            rd_d  = rd_f;
            wr    = 1'b1;
            imm_d = imm_u;
            alu_d = AluAdd;
         end
         OpcAuipc: begin
            rd_d  = rd_f;
            wr    = 1'b1;
            imm_d = imm_u;
            alu_d = AluAuipc;
         end
         default: ill_d = 1'b1;
      endcase
      if (ill_d) begin
         alu_d = AluNop;
         rs1_d = '0;
         rs2_d = '0;
         rd_d  = '0;
         imm_d = '0;
         wr    = 1'b0;
      end
      we_d = wr && (rd_d != '0);
   end

   // Flush wins over accept and also clears dec_valid while stalled.
   always_ff @(posedge clk) begin
      if (rst_b) begin
         valid_q <= 1'b0;
         alu_q   <= AluNop;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rd_q    <= '0;
         imm_q   <= '0;
         we_q    <= 1'b0;
         ill_q   <= 1'b0;
      end else if (bus.flush) begin
         valid_q <= 1'b0;
      end else if (!bus.stall) begin
         valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            alu_q <= alu_d;
            rs1_q <= rs1_d;
            rs2_q <= rs2_d;
            rd_q  <= rd_d;
            imm_q <= imm_d;
            we_q  <= we_d;
            ill_q <= ill_d;
         end
      end
   end

   regnum_t line_in, line_out;

   always_comb begin
      line_in.valid = valid_q && !bus.flush;
      line_in.rs1   = RegAw'(rs1_q);
      line_in.rs2   = RegAw'(rs2_q);
      line_in.rd    = RegAw'(rd_q);
      line_in.we    = we_q;
   end

   regnum_delay_line #(
      .DEPTH (DELAY_STAGES),
      .W     ($bits(regnum_t))
   ) u_delay (
      .clk_i (clk),
      .clr_i (rst_b),
      .en_i  (!bus.stall),
      .d_i   (line_in),
      .q_o   (line_out)
   );

   assign bus.in_ready    = !bus.stall && !rst_b;
   assign bus.dec_valid   = valid_q;
   assign bus.dec_rs1     = rs1_q;
   assign bus.dec_rs2     = rs2_q;
   assign bus.dec_rd      = rd_q;
   assign bus.dec_imm     = imm_q;
   assign bus.dec_alu     = alu_q;
   assign bus.dec_we      = we_q;
   assign bus.dec_illegal = ill_q;
   assign bus.wb_valid    = line_out.valid;
   assign bus.wb_rs1      = REG_AW'(line_out.rs1);
   assign bus.wb_rs2      = REG_AW'(line_out.rs2);
   assign bus.wb_rd       = REG_AW'(line_out.rd);
   assign bus.wb_we       = line_out.we;

endmodule

// File: tb/tb_rv_decode_pipe.sv
// Directed bench: RV32 / 4-stage instance and RV64 / 1-stage instance.
module tb_rv_decode_pipe;

   logic clk;
   logic rst_b;
   int   checks = 0;
   int   errors = 0;

   rv_decode_pipe_if #(.XLEN(32), .REG_AW(5)) bus_a ();
   rv_decode_pipe_if #(.XLEN(64), .REG_AW(5)) bus_b ();

   rv_decode_pipe #(.XLEN(32), .DELAY_STAGES(4), .REG_AW(5)) u_dut_a (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus_a)
   );

   rv_decode_pipe #(.XLEN(64), .DELAY_STAGES(1), .REG_AW(5)) u_dut_b (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_a(input logic v, input logic [31:0] i, input logic st, input logic fl);
      bus_a.in_valid = v;
      bus_a.inst     = i;
      bus_a.stall    = st;
      bus_a.flush    = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_b(input logic v, input logic [31:0] i, input logic st, input logic fl);
      bus_b.in_valid = v;
      bus_b.inst     = i;
      bus_b.stall    = st;
      bus_b.flush    = fl;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_b = 1'b1;
      bus_a.in_valid = 1'b0; bus_a.inst = '0; bus_a.stall = 1'b0; bus_a.flush = 1'b0;
      bus_b.in_valid = 1'b0; bus_b.inst = '0; bus_b.stall = 1'b0; bus_b.flush = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;

      chk("rst in_ready",    64'(bus_a.in_ready), 64'd0);
      chk("rst dec_valid",   64'(bus_a.dec_valid), 64'd0);
      chk("rst wb_valid",    64'(bus_a.wb_valid), 64'd0);
      chk("rst dec_alu",     64'(bus_a.dec_alu), 64'hF);
      chk("rst dec_imm",     64'(bus_a.dec_imm), 64'd0);
      chk("rst dec_we",      64'(bus_a.dec_we), 64'd0);
      chk("rst dec_illegal", 64'(bus_a.dec_illegal), 64'd0);
      chk("rst dec_rd",      64'(bus_a.dec_rd), 64'd0);
      chk("rst b dec_alu",   64'(bus_b.dec_alu), 64'hF);
      chk("rst b wb_valid",  64'(bus_b.wb_valid), 64'd0);

      rst_b = 1'b0;
      #1;
      chk("in_ready idle", 64'(bus_a.in_ready), 64'd1);

      // addi x5,x0,7
      drive_a(1'b1, 32'h00700293, 1'b0, 1'b0);
      chk("addi valid", 64'(bus_a.dec_valid), 64'd1);
      chk("addi rd",    64'(bus_a.dec_rd), 64'd5);
      chk("addi rs1",   64'(bus_a.dec_rs1), 64'd0);
      chk("addi imm",   64'(bus_a.dec_imm), 64'd7);
      chk("addi alu",   64'(bus_a.dec_alu), 64'h2);
      chk("addi we",    64'(bus_a.dec_we), 64'd1);

      // sub x3,x1,x2
      drive_a(1'b1, 32'h402081B3, 1'b0, 1'b0);
      chk("sub alu", 64'(bus_a.dec_alu), 64'h4);
      chk("sub rs1", 64'(bus_a.dec_rs1), 64'd1);
      chk("sub rs2", 64'(bus_a.dec_rs2), 64'd2);
      chk("sub rd",  64'(bus_a.dec_rd), 64'd3);

      // srai x1,x1,3
      drive_a(1'b1, 32'h4030D093, 1'b0, 1'b0);
      chk("srai alu", 64'(bus_a.dec_alu), 64'h9);
      chk("srai imm", 64'(bus_a.dec_imm), 64'd3);
      chk("srai rs2", 64'(bus_a.dec_rs2), 64'd0);

      // sw x2,8(x1); addi not yet at writeback
      drive_a(1'b1, 32'h0020A423, 1'b0, 1'b0);
      chk("sw alu", 64'(bus_a.dec_alu), 64'hC);
      chk("sw imm", 64'(bus_a.dec_imm), 64'd8);
      chk("sw we",  64'(bus_a.dec_we), 64'd0);
      chk("sw rd",  64'(bus_a.dec_rd), 64'd0);
      chk("sw rs2", 64'(bus_a.dec_rs2), 64'd2);
      chk("wb early valid", 64'(bus_a.wb_valid), 64'd0);

      // jal x0,16; addi retires
      drive_a(1'b1, 32'h0100006F, 1'b0, 1'b0);
      chk("jal alu", 64'(bus_a.dec_alu), 64'hB);
      chk("jal we",  64'(bus_a.dec_we), 64'd0);
      chk("jal imm", 64'(bus_a.dec_imm), 64'd16);
      chk("wb addi valid", 64'(bus_a.wb_valid), 64'd1);
      chk("wb addi rd",    64'(bus_a.wb_rd), 64'd5);
      chk("wb addi we",    64'(bus_a.wb_we), 64'd1);

      // opcode 0x7F; sub retires
      drive_a(1'b1, 32'h0000007F, 1'b0, 1'b0);
      chk("ill flag",  64'(bus_a.dec_illegal), 64'd1);
      chk("ill valid", 64'(bus_a.dec_valid), 64'd1);
      chk("ill alu",   64'(bus_a.dec_alu), 64'hF);
      chk("ill we",    64'(bus_a.dec_we), 64'd0);
      chk("wb sub rd",  64'(bus_a.wb_rd), 64'd3);
      chk("wb sub rs2", 64'(bus_a.wb_rs2), 64'd2);

      // addi x6,x0,-1 resumes stream; srai retires
      drive_a(1'b1, 32'hFFF00313, 1'b0, 1'b0);
      chk("neg illegal", 64'(bus_a.dec_illegal), 64'd0);
      chk("neg imm",     64'(bus_a.dec_imm), 64'hFFFF_FFFF);
      chk("neg rd",      64'(bus_a.dec_rd), 64'd6);
      chk("wb srai rd",  64'(bus_a.wb_rd), 64'd1);

      // three stalled cycles with add x7,x1,x2 presented
      drive_a(1'b1, 32'h002083B3, 1'b1, 1'b0);
      chk("stall in_ready", 64'(bus_a.in_ready), 64'd0);
      drive_a(1'b1, 32'h002083B3, 1'b1, 1'b0);
      drive_a(1'b1, 32'h002083B3, 1'b1, 1'b0);
      chk("stall dec_rd", 64'(bus_a.dec_rd), 64'd6);
      chk("stall dec_valid", 64'(bus_a.dec_valid), 64'd1);
      chk("stall wb_rd", 64'(bus_a.wb_rd), 64'd1);
      chk("stall wb_valid", 64'(bus_a.wb_valid), 64'd1);

      // release: add accepted, sw retires 3 cycles late
      drive_a(1'b1, 32'h002083B3, 1'b0, 1'b0);
      chk("add rd",     64'(bus_a.dec_rd), 64'd7);
      chk("add alu",    64'(bus_a.dec_alu), 64'h2);
      chk("wb sw valid", 64'(bus_a.wb_valid), 64'd1);
      chk("wb sw we",    64'(bus_a.wb_we), 64'd0);
      chk("wb sw rs2",   64'(bus_a.wb_rs2), 64'd2);

      // flush with add in decode; xor x9 presented is dropped
      drive_a(1'b1, 32'h0020C4B3, 1'b0, 1'b1);
      chk("flush dec_valid", 64'(bus_a.dec_valid), 64'd0);
      chk("wb jal valid",    64'(bus_a.wb_valid), 64'd1);
      chk("wb jal we",       64'(bus_a.wb_we), 64'd0);
      drive_a(1'b0, 32'h0, 1'b0, 1'b0);
      chk("wb ill valid", 64'(bus_a.wb_valid), 64'd1);
      chk("wb ill rd",    64'(bus_a.wb_rd), 64'd0);
      drive_a(1'b0, 32'h0, 1'b0, 1'b0);
      chk("wb neg valid", 64'(bus_a.wb_valid), 64'd1);
      chk("wb neg rd",    64'(bus_a.wb_rd), 64'd6);
      drive_a(1'b0, 32'h0, 1'b0, 1'b0);
      chk("wb flushed valid", 64'(bus_a.wb_valid), 64'd0);
      chk("wb flushed rd",    64'(bus_a.wb_rd), 64'd7);

      // lui x10,0x12345; dropped xor never appears
      drive_a(1'b1, 32'h12345537, 1'b0, 1'b0);
      chk("wb bubble valid", 64'(bus_a.wb_valid), 64'd0);
      chk("lui alu", 64'(bus_a.dec_alu), 64'h2);
      chk("lui imm", 64'(bus_a.dec_imm), 64'h1234_5000);
      chk("lui rs1", 64'(bus_a.dec_rs1), 64'd0);
      chk("lui rd",  64'(bus_a.dec_rd), 64'd10);

      // slli with shamt bit 5 set is illegal at XLEN=32
      drive_a(1'b1, 32'h02109093, 1'b0, 1'b0);
      chk("slli32 illegal", 64'(bus_a.dec_illegal), 64'd1);
      chk("slli32 rd",      64'(bus_a.dec_rd), 64'd0);

      // reset mid-stream
      rst_b = 1'b1;
      drive_a(1'b1, 32'h00700293, 1'b0, 1'b0);
      chk("mid rst dec_valid", 64'(bus_a.dec_valid), 64'd0);
      chk("mid rst illegal",   64'(bus_a.dec_illegal), 64'd0);
      chk("mid rst alu",       64'(bus_a.dec_alu), 64'hF);
      chk("mid rst wb_valid",  64'(bus_a.wb_valid), 64'd0);
      chk("mid rst in_ready",  64'(bus_a.in_ready), 64'd0);
      rst_b = 1'b0;
      bus_a.in_valid = 1'b0;

      // XLEN=64, DELAY_STAGES=1
      drive_b(1'b1, 32'h00700293, 1'b0, 1'b0);
      chk("b addi valid", 64'(bus_b.dec_valid), 64'd1);
      chk("b addi imm",   64'(bus_b.dec_imm), 64'd7);
      chk("b wb early",   64'(bus_b.wb_valid), 64'd0);
      drive_b(1'b1, 32'h02109093, 1'b0, 1'b0);
      chk("b slli alu",     64'(bus_b.dec_alu), 64'h1);
      chk("b slli imm",     64'(bus_b.dec_imm), 64'd33);
      chk("b slli illegal", 64'(bus_b.dec_illegal), 64'd0);
      chk("b wb addi valid", 64'(bus_b.wb_valid), 64'd1);
      chk("b wb addi rd",    64'(bus_b.wb_rd), 64'd5);
      drive_b(1'b1, 32'hFFF00313, 1'b0, 1'b0);
      chk("b neg imm",   64'(bus_b.dec_imm), 64'hFFFF_FFFF_FFFF_FFFF);
      chk("b wb slli rd", 64'(bus_b.wb_rd), 64'd1);
      drive_b(1'b1, 32'h00700293, 1'b0, 1'b1);
      chk("b flush dec_valid", 64'(bus_b.dec_valid), 64'd0);
      chk("b flush wb_valid",  64'(bus_b.wb_valid), 64'd0);
      chk("b flush wb_rd",     64'(bus_b.wb_rd), 64'd6);
      drive_b(1'b0, 32'h0, 1'b0, 1'b0);
      chk("b bubble wb_valid", 64'(bus_b.wb_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rv_decode_pipe.md
# rv_decode_pipe

Parametrised RV32I/RV64I instruction decoder with a registered decode stage and a configurable-depth register-number delay line for writeback. It sits between instruction fetch and the register file/ALU. It extends the current decoder with:
- full R-type and I-type coverage;
- illegal-opcode flagging;
- x0 write suppression;
- valid/stall/flush handshaking;
- a delay depth set by parameter rather than fixed at four stages.

## Interface
Parameters:
- XLEN, 32, data width; legal values 32 or 64. Sets the immediate width and shamt width (5 bits at 32, 6 bits at 64).
- DELAY_STAGES, 4, number of delay-line stages between decode and writeback outputs (≥1).
- REG_AW, 5, register-number width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_b  in  1  reset; synchronous, active-high.
- in_valid  in  1  inst is valid this cycle.
- in_ready  out  1  decoder accepts inst; equals !stall.
- inst  in  32  instruction word.
- stall  in  1  freezes decode register and delay line.
- flush  in  1  invalidates the decode-stage instruction.
- dec_valid  out  1  decode outputs hold a valid instruction.
- dec_rs1, dec_rs2, dec_rd  out  REG_AW  decoded register numbers.
- dec_imm  out  XLEN  sign-extended immediate.
- dec_alu  out  4  ALU control code.
- dec_we  out  1  instruction writes rd (forced 0 when rd==0).
- dec_illegal  out  1  unsupported opcode or funct combination.
- wb_valid  out  1  delayed instruction is valid.
- wb_rs1, wb_rs2, wb_rd  out  REG_AW  register numbers delayed DELAY_STAGES cycles.
- wb_we  out  1  delayed write enable.

## Operation
- Accept condition: in_valid && !stall. On accept, the decode register loads the decoded fields and dec_valid is set to 1.
- No accept and no stall: dec_valid is set to 0; all other decode fields are don't-care but hold their previous value.
- ALU codes:
  - AND 0000, SLL 0001, ADD 0010, OR 0011, SUB 0100, SLT 0101, XOR 0110, SLTU 0111;
  - SRL 1000, SRA 1001, JALR 1010, JAL 1011, STORE 1100, LOAD 1101, AUIPC 1110, NOP/BRANCH 1111.
- Opcodes:
  - 0x33 R-type: add, sub, sll, slt, sltu, xor, srl, sra, or, and.
  - 0x13 I-type, including shift-immediates. For shifts, dec_imm = zero-extended inst[19+log2(XLEN):20]. inst[30] selects SRA.
  - 0x03 load.
  - 0x23 store.
  - 0x63 branch.
  - 0x6F jal.
  - 0x67 jalr.
  - 0x37 lui: ADD with rs1=0.
  - 0x17 auipc.
- Immediates are sign-extended to XLEN per the RISC-V format for each opcode.
- Store and branch: dec_rd=0 and dec_we=0.
- lui, auipc and jal: dec_rs1=0. dec_rs2=0 wherever rs2 is not used.
- Illegal instruction (unknown opcode, or a funct7/funct3 combination outside the list above):
  - dec_illegal=1, dec_valid=1, dec_alu=1111, dec_we=0;
  - all register numbers are 0.
- Delay line:
  - DELAY_STAGES entries, each holding {valid, rs1, rs2, rd, we}.
  - Stage 0 loads {dec_valid && !flush, dec_*} each non-stalled cycle, and the entries shift by one.
  - wb_* outputs are the last stage.
- Flush:
  - Clears dec_valid at the edge where it is sampled, with priority over accept; an in_valid instruction presented that cycle is dropped.
  - The instruction in the decode register enters the delay line with valid=0.
  - Older delay-line entries are unaffected.
- Stall: nothing changes, including delay-line contents. Stall and flush together: flush clears dec_valid, and the delay line still holds.

## Timing
- Reset values:
  - dec_valid=0, wb_valid=0, dec_illegal=0, dec_we=0, wb_we=0;
  - all register numbers 0, dec_imm=0, dec_alu=1111;
  - every delay stage is cleared.
- in_ready is combinational from stall; in_ready=0 while rst_b is high.
- Decode latency: 1 cycle. An instruction accepted at edge N appears on dec_* after edge N.
- Writeback latency: its register numbers appear on wb_* after edge N+DELAY_STAGES, provided there is no stall; each stalled cycle adds one.
- Reset asserted mid-stream: on that edge every in-flight entry is discarded and all outputs take their reset values.

## Structure
- Package rv_decode_pkg:
  - opcode localparams;
  - alu_op_t enum holding the 4-bit codes above;
  - a packed struct regnum_t {valid, rs1, rs2, rd, we} parametrised by REG_AW.
- Sub-module regnum_delay_line (parameters DEPTH, W):
  - shift register with enable (!stall) and synchronous clear;
  - instantiated once on the packed regnum_t.
- Combinational decode is an always_comb block in rv_decode_pipe, feeding the registered stage.

## Test plan
- Reset, then addi x5,x0,7 (0x00700293) -> one cycle later dec_valid=1, dec_rd=5, dec_rs1=0, dec_imm=7, dec_alu=0010, dec_we=1. Four cycles after that, wb_valid=1 and wb_rd=5.
- sub x3,x1,x2 (0x402081B3) -> dec_alu=0100, dec_rs1=1, dec_rs2=2, dec_rd=3. srai x1,x1,3 (0x4030D093) -> dec_alu=1001, dec_imm=3.
- sw x2,8(x1) (0x0020A423) -> dec_alu=1100, dec_imm=8, dec_we=0, dec_rd=0. jal x0 -> dec_we=0.
- Opcode 0x7F -> dec_illegal=1, dec_alu=1111, dec_we=0. Stream resumes on the next instruction.
- Stall held 3 cycles mid-stream -> wb_* and dec_* frozen, in_ready=0; each wb_* arrival is delayed by exactly 3 cycles.
- Flush with a valid decode-stage instruction -> dec_valid=0 on the next cycle; that instruction reaches wb with wb_valid=0. Older entries still retire with wb_valid=1. Repeat with DELAY_STAGES=1 and XLEN=64.
